dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 30 +++
 rtl/dmem_arbiter.sv | 80 ++++++++
 tb/tb_dmem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of both requester ports and the data-memory bus for dmem_arbiter.
// slave is the arbiter's view; master is the requesters plus memory side.
interface dmem_arbiter_if #(parameter int ADDR_W = 32);
    logic p0_req, p0_we, p0_signed, p0_ack, p0_err;
    logic [1:0] p0_size;
    logic [ADDR_W-1:0] p0_addr;
    logic [31:0] p0_wdata, p0_rdata;
    logic p1_req, p1_we, p1_signed, p1_ack, p1_err;
    logic [1:0] p1_size;
    logic [ADDR_W-1:0] p1_addr;
    logic [31:0] p1_wdata, p1_rdata;
    logic mem_we;
    logic [3:0] mem_be;
    logic [ADDR_W-1:0] mem_a;
    logic [31:0] mem_wd, mem_rd;
    modport slave (
        input p0_req, p0_we, p0_signed, p0_size, p0_addr, p0_wdata,
        input p1_req, p1_we, p1_signed, p1_size, p1_addr, p1_wdata,
        output p0_ack, p0_err, p0_rdata, p1_ack, p1_err, p1_rdata,
        output mem_we, mem_be, mem_a, mem_wd,
        input mem_rd
    );
    modport master (
        output p0_req, p0_we, p0_signed, p0_size, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_signed, p1_size, p1_addr, p1_wdata,
        input p0_ack, p0_err, p0_rdata, p1_ack, p1_err, p1_rdata,
        input mem_we, mem_be, mem_a, mem_wd,
        output mem_rd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester data-memory arbiter with byte/half/word access and load extension.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 wins simultaneous requests.
module dmem_arbiter #(parameter int ADDR_W = 32) (
    input logic clk,
    input logic reset,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state;
    logic id, we, sgn, bad, win, w_we, w_sgn, w_bad;
    logic [1:0] size, lo, w_size;
    logic [ADDR_W-1:0] w_addr;
    logic [3:0] w_be;
    logic [31:0] w_wdata, w_wd, sh, ld;
`ifdef DMEM_ARB_RR_EN
    logic last;
    assign win = (bus.p0_req && bus.p1_req) ? ~last : bus.p1_req;
`else
    assign win = ~bus.p0_req;
`endif
    always_comb begin
        w_we = win ? bus.p1_we : bus.p0_we;
        w_sgn = win ? bus.p1_signed : bus.p0_signed;
        w_size = win ? bus.p1_size : bus.p0_size;
        w_addr = win ? bus.p1_addr : bus.p0_addr;
        w_wdata = win ? bus.p1_wdata : bus.p0_wdata;
        w_bad = w_size == 2'd3 || (w_size == 2'd1 && w_addr[0]) || (w_size == 2'd2 && w_addr[1:0] != 2'd0);
        w_be = w_size == 2'd0 ? 4'b0001 << w_addr[1:0] : w_size == 2'd1 ? 4'b0011 << w_addr[1:0] : 4'b1111;
        w_wd = w_size == 2'd0 ? {4{w_wdata[7:0]}} : w_size == 2'd1 ? {2{w_wdata[15:0]}} : w_wdata;
        sh = bus.mem_rd >> {lo, 3'b000};
        ld = size == 2'd0 ? {{24{sgn & sh[7]}}, sh[7:0]} :
             size == 2'd1 ? {{16{sgn & sh[15]}}, sh[15:0]} : sh;
    end
    // Memory strobes are registered at grant so they are stable for the whole ACCESS cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            {id, we, sgn, bad, size, lo} <= '0;
            bus.mem_we <= 1'b0;
            bus.mem_be <= 4'd0;
            bus.mem_a <= '0;
            bus.mem_wd <= 32'd0;
            {bus.p0_ack, bus.p0_err, bus.p1_ack, bus.p1_err} <= 4'd0;
            bus.p0_rdata <= 32'd0;
            bus.p1_rdata <= 32'd0;
`ifdef DMEM_ARB_RR_EN
            last <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: if (bus.p0_req || bus.p1_req) begin
                    state <= ACCESS;
                    {id, we, sgn, bad, size, lo} <= {win, w_we, w_sgn, w_bad, w_size, w_addr[1:0]};
                    bus.mem_we <= w_we & ~w_bad;
                    bus.mem_be <= w_bad ? 4'd0 : w_be;
                    bus.mem_a <= {w_addr[ADDR_W-1:2], 2'b00};
                    bus.mem_wd <= w_wd;
`ifdef DMEM_ARB_RR_EN
                    last <= win;
`endif
                end
                ACCESS: begin
                    state <= DONE;
                    bus.mem_we <= 1'b0;
                    bus.mem_be <= 4'd0;
                    if (!bad && !we) begin
                        if (id) bus.p1_rdata <= ld;
                        else bus.p0_rdata <= ld;
                    end
                    {bus.p0_ack, bus.p0_err, bus.p1_ack, bus.p1_err} <= {~id, ~id & bad, id, id & bad};
                end
                DONE: begin
                    state <= IDLE;
                    {bus.p0_ack, bus.p0_err, bus.p1_ack, bus.p1_err} <= 4'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed checks of dmem_arbiter against a byte-array memory model.
// Build with DMEM_ARB_RR_EN defined to expect round-robin arbitration.
module tb_dmem_arbiter;
    logic clk = 0, reset = 1;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32)) bus();
    dmem_arbiter #(.ADDR_W(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic [31:0] mem [0:63];
    logic bd_we = 0;
    logic [5:0] bd_a = 0;
    logic [31:0] bd_d = 0;
    always @(posedge clk) begin
        if (bd_we) mem[bd_a] <= bd_d;
        else if (bus.mem_we)
            for (int k = 0; k < 4; k++)
                if (bus.mem_be[k]) mem[bus.mem_a[7:2]][8*k +: 8] <= bus.mem_wd[8*k +: 8];
    end
    assign bus.mem_rd = mem[bus.mem_a[7:2]];

    logic [7:0] rb [0:255];
    logic [31:0] exp_rdata [2];

    function automatic logic legal(input logic [1:0] sz, input int a);
        return sz == 2'd0 || (sz == 2'd1 && a % 2 == 0) || (sz == 2'd2 && a % 4 == 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input int a);
        logic [31:0] v = 0;
        int n = 1 << sz;
        for (int k = 0; k < n; k++) v = v | (32'(rb[a + k]) << (8 * k));
        if (sg && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] sz, input int a);
        logic [3:0] b = 0;
        if (legal(sz, a)) for (int k = 0; k < (1 << sz); k++) b[a % 4 + k] = 1'b1;
        return b;
    endfunction

    function automatic void model_apply(input int p, input logic w, input logic [1:0] sz, input logic sg, input int a, input logic [31:0] d);
        if (!legal(sz, a)) return;
        if (w) for (int k = 0; k < (1 << sz); k++) rb[a + k] = d[8*k +: 8];
        else exp_rdata[p] = ref_load(sz, sg, a);
    endfunction

    int lat;
    logic acc_we, got_err, other_ack;
    logic [3:0] acc_be;
    logic [31:0] acc_wd, acc_a, got_rdata;

    task automatic txn(input int p, input logic w, input logic [1:0] sz, input logic sg, input int a, input logic [31:0] d);
        @(negedge clk);
        if (p == 0) begin
            bus.p0_we = w; bus.p0_size = sz; bus.p0_signed = sg; bus.p0_addr = 32'(a); bus.p0_wdata = d; bus.p0_req = 1;
        end else begin
            bus.p1_we = w; bus.p1_size = sz; bus.p1_signed = sg; bus.p1_addr = 32'(a); bus.p1_wdata = d; bus.p1_req = 1;
        end
        lat = -1;
        other_ack = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) begin
                acc_we = bus.mem_we; acc_be = bus.mem_be; acc_wd = bus.mem_wd; acc_a = bus.mem_a;
            end
            if (p == 0 ? bus.p1_ack : bus.p0_ack) other_ack = 1;
            if (p == 0 ? bus.p0_ack : bus.p1_ack) begin
                lat = c;
                got_err = p == 0 ? bus.p0_err : bus.p1_err;
                got_rdata = p == 0 ? bus.p0_rdata : bus.p1_rdata;
                break;
            end
        end
        bus.p0_req = 0;
        bus.p1_req = 0;
        model_apply(p, w, sz, sg, a, d);
    endtask

    task automatic apply_reset();
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        exp_rdata[0] = 0;
        exp_rdata[1] = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 64; i++) begin
            bd_we = 1; bd_a = 6'(i); bd_d = $urandom;
            for (int k = 0; k < 4; k++) rb[4*i + k] = bd_d[8*k +: 8];
            @(negedge clk);
        end
        bd_we = 0;
        checks++;
        if ({bus.mem_we, bus.mem_be, bus.mem_a, bus.mem_wd} !== 69'd0) begin
            errors++; $display("FAIL reset_mem got we=%b be=%b a=%h wd=%h exp all zero", bus.mem_we, bus.mem_be, bus.mem_a, bus.mem_wd);
        end
        checks++;
        if ({bus.p0_ack, bus.p0_err, bus.p1_ack, bus.p1_err, bus.p0_rdata, bus.p1_rdata} !== 68'd0) begin
            errors++; $display("FAIL reset_ports got ack/err=%b%b%b%b rdata=%h/%h exp all zero",
                bus.p0_ack, bus.p0_err, bus.p1_ack, bus.p1_err, bus.p0_rdata, bus.p1_rdata);
        end
        apply_reset();
    endtask

    task automatic test_word();
        txn(0, 1, 2'd2, 0, 'h10, 32'hDEADBEEF);
        checks++;
        if (acc_be !== 4'b1111 || acc_we !== 1'b1) begin
            errors++; $display("FAIL word_store got be=%b we=%b exp 1111 1", acc_be, acc_we);
        end
        txn(0, 0, 2'd2, 0, 'h10, 0);
        checks++;
        if (got_rdata !== 32'hDEADBEEF || got_err !== 1'b0 || lat != 2) begin
            errors++; $display("FAIL word_load got rdata=%h err=%b lat=%0d exp deadbeef 0 2", got_rdata, got_err, lat);
        end
    endtask

    task automatic test_byte();
        txn(1, 1, 2'd0, 0, 'h23, 32'h80);
        checks++;
        if (acc_be !== 4'b1000 || acc_wd !== 32'h80808080 || acc_a !== 32'h20) begin
            errors++; $display("FAIL byte_store got be=%b wd=%h a=%h exp 1000 80808080 20", acc_be, acc_wd, acc_a);
        end
        txn(1, 0, 2'd0, 1, 'h23, 0);
        checks++;
        if (got_rdata !== 32'hFFFFFF80 || lat != 2) begin
            errors++; $display("FAIL byte_load_s got %h lat=%0d exp ffffff80 2", got_rdata, lat);
        end
        txn(1, 0, 2'd0, 0, 'h23, 0);
        checks++;
        if (got_rdata !== 32'h00000080) begin
            errors++; $display("FAIL byte_load_u got %h exp 00000080", got_rdata);
        end
    endtask

    task automatic test_half();
        txn(0, 1, 2'd1, 0, 'h42, 32'h1234);
        checks++;
        if (acc_be !== 4'b1100 || acc_wd !== 32'h12341234) begin
            errors++; $display("FAIL half_store got be=%b wd=%h exp 1100 12341234", acc_be, acc_wd);
        end
        txn(0, 0, 2'd1, 0, 'h42, 0);
        checks++;
        if (got_rdata !== 32'h00001234 || got_err !== 1'b0) begin
            errors++; $display("FAIL half_load got %h err=%b exp 00001234 0", got_rdata, got_err);
        end
        txn(0, 0, 2'd1, 0, 'h41, 0);
        checks++;
        if (got_err !== 1'b1 || acc_we !== 1'b0 || acc_be !== 4'd0 || got_rdata !== 32'h00001234 || lat != 2) begin
            errors++; $display("FAIL half_misaligned got err=%b we=%b be=%b rdata=%h lat=%0d exp 1 0 0000 00001234 2",
                got_err, acc_we, acc_be, got_rdata, lat);
        end
    endtask

    task automatic test_arb();
        int exp_p, got_p, last;
        logic both;
        apply_reset();
        @(negedge clk);
        bus.p0_we = 0; bus.p0_size = 2'd2; bus.p0_signed = 0; bus.p0_addr = 0;
        bus.p1_we = 0; bus.p1_size = 2'd2; bus.p1_signed = 0; bus.p1_addr = 4;
        bus.p0_req = 1; bus.p1_req = 1;
        last = 1;
        both = 0;
        for (int t = 0; t < 4; t++) begin
            exp_p = RR ? 1 - last : 0;
            got_p = -1;
            for (int c = 0; c < 10 && got_p < 0; c++) begin
                @(negedge clk);
                if (bus.p0_ack && bus.p1_ack) both = 1;
                if (bus.p0_ack) got_p = 0;
                else if (bus.p1_ack) got_p = 1;
            end
            checks++;
            if (got_p != exp_p || both) begin
                errors++; $display("FAIL arb_grant%0d got port %0d (both=%b) exp port %0d", t, got_p, both, exp_p);
            end
            last = exp_p;
        end
        bus.p0_req = 0;
        bus.p1_req = 0;
        model_apply(0, 0, 2'd2, 0, 0, 0);
        if (RR) model_apply(1, 0, 2'd2, 0, 4, 0);
    endtask

    task automatic test_reset_mid();
        logic seen;
        txn(0, 1, 2'd2, 0, 'h30, 32'h11223344);
        @(negedge clk);
        bus.p0_we = 1; bus.p0_size = 2'd2; bus.p0_addr = 'h30; bus.p0_wdata = 32'hCAFEF00D; bus.p0_req = 1;
        @(negedge clk);
        checks++;
        if (bus.mem_we !== 1'b1) begin
            errors++; $display("FAIL abort_access got mem_we=%b exp 1", bus.mem_we);
        end
        #1 reset = 1;
        #1;
        checks++;
        if (bus.mem_we !== 1'b0 || bus.mem_be !== 4'd0) begin
            errors++; $display("FAIL abort_async got we=%b be=%b exp 0 0000", bus.mem_we, bus.mem_be);
        end
        @(negedge clk);
        bus.p0_req = 0;
        reset = 0;
        exp_rdata[0] = 0;
        exp_rdata[1] = 0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.p0_ack || bus.p1_ack) seen = 1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL abort_noack got ack seen=%b exp 0", seen);
        end
        txn(0, 0, 2'd2, 0, 'h30, 0);
        checks++;
        if (got_rdata !== 32'h11223344 || lat != 2) begin
            errors++; $display("FAIL abort_mem got %h lat=%0d exp 11223344 2", got_rdata, lat);
        end
    endtask

    task automatic test_random();
        int p, a;
        logic w, sg, ok, lanes_ok;
        logic [1:0] sz;
        logic [31:0] d, er;
        logic [3:0] eb;
        for (int i = 0; i < 60; i++) begin
            p = int'($urandom_range(0, 1));
            w = 1'($urandom);
            sg = 1'($urandom);
            sz = 2'($urandom_range(0, 3));
            a = int'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a = a & ~((1 << sz) - 1);
            d = $urandom;
            ok = legal(sz, a);
            eb = ref_be(sz, a);
            er = (ok && !w) ? ref_load(sz, sg, a) : exp_rdata[p];
            txn(p, w, sz, sg, a, d);
            lanes_ok = 1;
            if (ok && w)
                for (int k = 0; k < (1 << sz); k++)
                    if (acc_wd[8 * (a % 4 + k) +: 8] !== d[8*k +: 8]) lanes_ok = 0;
            checks++;
            if (lat != 2 || other_ack !== 1'b0 || got_err !== !ok) begin
                errors++; $display("FAIL rand%0d_hs got lat=%0d other=%b err=%b exp 2 0 %b", i, lat, other_ack, got_err, !ok);
            end
            checks++;
            if (acc_we !== (w & ok) || acc_be !== eb || acc_a !== 32'(a & ~3) || !lanes_ok) begin
                errors++; $display("FAIL rand%0d_bus got we=%b be=%b a=%h lanes=%b exp %b %b %h 1",
                    i, acc_we, acc_be, acc_a, lanes_ok, w & ok, eb, 32'(a & ~3));
            end
            checks++;
            if (got_rdata !== er) begin
                errors++; $display("FAIL rand%0d_rdata p%0d sz=%0d sg=%b a=%h got %h exp %h", i, p, sz, sg, a, got_rdata, er);
            end
        end
    endtask

    initial begin
        {bus.p0_req, bus.p0_we, bus.p0_signed, bus.p0_size, bus.p0_addr, bus.p0_wdata} = '0;
        {bus.p1_req, bus.p1_we, bus.p1_signed, bus.p1_size, bus.p1_addr, bus.p1_wdata} = '0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_arb();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
